queue_ingress: RTL

//  Upstream feeder for the selectable-read queue. Accepts a valid/ready word stream

---
 rtl/queue_ingress_if.sv | 26 ++
 rtl/queue_ingress.sv | 115 +++++++++++
 2 files changed

// File: rtl/queue_ingress_if.sv
// Producer stream and queue push bundle for queue_ingress.
// master drives words and q_full; slave (the ingress) drives s_ready, q_push, q_data.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface queue_ingress_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  q_full;
  logic                  q_push;
  logic [DATA_WIDTH-1:0] q_data;

  modport master (
    output s_data, s_valid, q_full,
    input  s_ready, q_push, q_data
  );

  modport slave (
    input  s_data, s_valid, q_full,
    output s_ready, q_push, q_data
  );
endinterface

// File: rtl/queue_ingress.sv
// 2-entry skid buffer feeding the queue; accepted words push one cycle later at the earliest.
// Define INGRESS_DROP_EN to discard the head word after STALL_LIMIT full cycles.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module queue_ingress #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  queue_ingress_if.slave       bus,
  output logic [1:0]           occ,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  accept;
  logic                  push;
  logic                  drop;

  // s_ready depends only on flops and reset, never on s_valid or q_full.
  assign bus.s_ready = (occ_q < 2'd2) & ~reset;
  assign push        = (occ_q != 2'd0) & ~bus.q_full & ~reset;
  assign bus.q_push  = push;
  assign bus.q_data  = mem_q[head_q];
  assign accept      = bus.s_valid & bus.s_ready;
  assign occ         = occ_q;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (accept) begin
      mem_d[tail_q] = bus.s_data;
      tail_d        = ~tail_q;
    end
    if (push | drop) begin
      head_d = ~head_q;
    end
    case ({accept, push | drop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
    mem_q <= mem_d;
  end

`ifdef INGRESS_DROP_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // q_full is rechecked so a drop can never coincide with a push.
  assign drop     = (state_q == STALL) & bus.q_full & (stall_cnt_q == STALL_LAST);
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    state_d     = IDLE;
    stall_cnt_d = '0;
    drop_cnt_d  = drop_cnt_q;
    if (occ_d != 2'd0) begin
      state_d = bus.q_full ? STALL : ACTIVE;
    end
    if (!drop && (state_q == STALL) && bus.q_full) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (drop && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
`else
  assign drop     = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule
